// File: rtl/zero_cross_pkg.sv
// rtl/zero_cross_pkg.sv - shared state encoding and threshold helper for zero-cross period measurement
package zero_cross_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } zc_state_t;

  // Returns {hi, lo}; both comparisons are signed and strict so samples equal to +/-thr stay in the band.
  function automatic logic [1:0] hyst_classify(input logic signed [63:0] x,
                                               input logic signed [63:0] thr);
    return {x > thr, x < -thr};
  endfunction

endpackage

// File: rtl/zc_hyst_slicer.sv
// rtl/zc_hyst_slicer.sv - hysteresis state machine producing a combinational rising-crossing strobe
module zc_hyst_slicer
  import zero_cross_pkg::*;
#(
  parameter int DIN_WIDTH = 24,
  parameter int HYST      = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DIN_WIDTH-1:0] din,
  input  logic                        din_valid,
  input  logic                        restart,
  output logic                        rise
);

  zc_state_t          state;
  zc_state_t          next_state;
  logic signed [63:0] din_ext;
  logic signed [63:0] thr;
  logic [1:0]         hl;
  logic               hi;
  logic               lo;

  assign din_ext = {{(64-DIN_WIDTH){din[DIN_WIDTH-1]}}, din};
  assign thr     = 64'(HYST);
  assign hl      = hyst_classify(din_ext, thr);
  assign hi      = hl[1];
  assign lo      = hl[0];

  always_comb begin
    next_state = state;
    case (state)
      ST_INIT: begin
        if (hi)      next_state = ST_HIGH;
        else if (lo) next_state = ST_LOW;
      end
      ST_LOW:  if (hi) next_state = ST_HIGH;
      ST_HIGH: if (lo) next_state = ST_LOW;
      default: next_state = ST_INIT;
    endcase
  end

  // Only a LOW->HIGH move counts as a crossing; leaving INIT never does.
  assign rise = din_valid && (state == ST_LOW) && hi;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_INIT;
    end else if (restart) begin
      state <= ST_INIT;
    end else if (din_valid) begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/get_zero_cross_period.sv
// rtl/get_zero_cross_period.sv - measures samples between rising zero crossings with signal-lost timeout
module get_zero_cross_period
  import zero_cross_pkg::*;
#(
  parameter int     DIN_WIDTH = 24,
  parameter int     HYST      = 64,
  parameter int     CNT_WIDTH = 32,
  parameter longint TIMEOUT   = 100000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DIN_WIDTH-1:0] din,
  input  logic                        din_valid,
  output logic [CNT_WIDTH-1:0]        period,
  output logic                        period_valid,
  output logic                        sig_lost
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  logic                 rise;
  logic                 armed;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 timeout_hit;

  // A crossing on the last allowed sample suppresses the timeout.
  assign timeout_hit = armed && din_valid && !rise && (cnt == CNT_LAST);

  zc_hyst_slicer #(
    .DIN_WIDTH (DIN_WIDTH),
    .HYST      (HYST)
  ) u_slicer (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .restart   (timeout_hit),
    .rise      (rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      armed        <= 1'b0;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      sig_lost     <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (din_valid) begin
        if (rise) begin
          cnt <= '0;
          if (armed) begin
            period       <= cnt + 1'b1;
            period_valid <= 1'b1;
            sig_lost     <= 1'b0;
          end else begin
            armed <= 1'b1;
          end
        end else if (timeout_hit) begin
          sig_lost <= 1'b1;
          armed    <= 1'b0;
          cnt      <= '0;
        end else if (armed) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_get_zero_cross_period.sv
// tb/tb_get_zero_cross_period.sv - scoreboard bench for get_zero_cross_period
module tb_get_zero_cross_period;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [23:0] din;
  logic               din_valid;
  logic [31:0]        period;
  logic               period_valid;
  logic               sig_lost;

  int                 n_pass = 0;
  int                 n_total = 0;
  int                 exp_q[$];

  get_zero_cross_period #(
    .DIN_WIDTH (24),
    .HYST      (64),
    .CNT_WIDTH (32),
    .TIMEOUT   (1000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_valid    (din_valid),
    .period       (period),
    .period_valid (period_valid),
    .sig_lost     (sig_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: every period_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && period_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", period, -1);
      end else begin
        check("period", period, exp_q.pop_front());
        check("sig_lost_on_pulse", sig_lost, 0);
      end
    end
  end

  task automatic send(input int v, input int gapmax);
    int g;
    din       = 24'(v);
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
    repeat (g) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic half(input int v, input int n, input int gapmax);
    for (int i = 0; i < n; i++) send(v, gapmax);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_period", period, 0);
    check("reset_period_valid", period_valid, 0);
    check("reset_sig_lost", sig_lost, 0);

    // Square wave, dense valids: first rise only arms.
    half(1000, 10, 0);
    half(-1000, 10, 0);
    half(1000, 10, 0);
    half(-1000, 10, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(20);
      half(1000, 10, 0);
      half(-1000, 10, 0);
    end
    check("square_sig_lost", sig_lost, 0);

    // Same wave with idle gaps between valids.
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(20);
      half(1000, 10, 11);
      half(-1000, 10, 11);
    end

    // In-band chatter until timeout.
    exp_q.push_back(20);
    send(1000, 0);
    for (int i = 0; i < 999; i++) send((i % 2 == 0) ? 60 : -60, 0);
    check("lost_after_999", sig_lost, 0);
    send(60, 0);
    check("lost_after_1000", sig_lost, 1);
    send(-1000, 0);
    send(1000, 0);
    check("lost_held_on_rearm", sig_lost, 1);
    half(-1000, 9, 0);
    exp_q.push_back(10);
    send(1000, 0);
    check("lost_cleared", sig_lost, 0);

    // Crossing on the timeout sample wins.
    send(1000, 0);
    half(-1000, 998, 0);
    exp_q.push_back(1000);
    send(1000, 0);
    check("priority_sig_lost", sig_lost, 0);

    // Band edges: +/-64 hold, +65 crosses.
    send(-1000, 0);
    send(64, 0);
    send(-64, 0);
    send(64, 0);
    exp_q.push_back(5);
    send(65, 0);

    // Mid-period reset discards progress.
    half(1000, 9, 0);
    half(-1000, 10, 0);
    exp_q.push_back(20);
    half(1000, 10, 0);
    half(-1000, 5, 0);
    do_reset();
    check("midrst_period", period, 0);
    check("midrst_period_valid", period_valid, 0);
    check("midrst_sig_lost", sig_lost, 0);
    half(1000, 10, 0);
    half(-1000, 10, 0);
    half(1000, 10, 0);
    half(-1000, 10, 0);
    exp_q.push_back(20);
    half(1000, 10, 0);
    check("period_held", period, 20);

    repeat (5) @(posedge clk);
    check("all_pulses_seen", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/get_zero_cross_period.md
Name: get_zero_cross_period

Overview:
- Measures the period of the zero-mean `ac_signal` produced by the moving-average stage.
- Sits directly downstream of that stage and consumes its `ac_signal` / `ac_signal_valid` as `din` / `din_valid`.
- Detects rising zero crossings with a symmetric hysteresis band.
- Reports the number of valid samples between consecutive rising crossings, plus a signal-lost flag when no crossing arrives within a timeout.

Parameters:
- DIN_WIDTH, 24: input sample width, signed two's complement.
- HYST, 64: hysteresis threshold magnitude. Must satisfy 0 <= HYST < 2^(DIN_WIDTH-1).
- CNT_WIDTH, 32: width of the sample counter and of the period output.
- TIMEOUT, 100000: valid-sample count without a rising crossing that declares the signal lost. Range 2 to 2^CNT_WIDTH-1.

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- din  in  DIN_WIDTH  signed AC sample.
- din_valid  in  1  one-cycle qualifier for `din`; may have arbitrary gaps between pulses.
- period  out  CNT_WIDTH  last measured period, in valid samples.
- period_valid  out  1  one-cycle pulse; `period` is updated on the same cycle.
- sig_lost  out  1  sticky signal-lost flag.

Behaviour:
- Clock and reset: one clock (`clk`); reset (`rst`) is synchronous and active-high.
- Reset values:
  - Outputs: period=0, period_valid=0, sig_lost=0.
  - Internal: state=ST_INIT, armed=0, cnt=0.
  - Reset asserted mid-measurement discards all progress. The first rising crossing after reset only re-arms.
- Sample processing: only cycles with din_valid=1 change state or count. Cycles with din_valid=0 hold everything, and period_valid=0 on them.
- Comparison: signed and strict.
  - hi = din > +HYST; lo = din < -HYST.
  - Samples with -HYST <= din <= +HYST hold the current state.
- State machine, evaluated on valid samples:
  - ST_INIT: hi -> ST_HIGH; lo -> ST_LOW. No event in either case.
  - ST_LOW: hi -> ST_HIGH and rise event.
  - ST_HIGH: lo -> ST_LOW.
  - No other transitions.
- Counting:
  - On a rise event with armed=0: armed<=1, cnt<=0, no output.
  - On a rise event with armed=1: period<=cnt+1, period_valid<=1, cnt<=0, sig_lost<=0.
  - On a valid sample without a rise event while armed=1: cnt<=cnt+1.
  - While armed=0, cnt holds 0.
- Latency: period_valid asserts on the clock edge that registers the crossing sample, i.e. it is visible the cycle after din_valid. Throughput is one sample per clock.
- Timeout:
  - Condition: armed=1, a valid sample with no rise event, and cnt==TIMEOUT-1.
  - Action: sig_lost<=1, state<=ST_INIT, armed<=0, cnt<=0.
  - sig_lost stays set until the next period_valid or rst.
- Simultaneous crossing and timeout: the crossing wins. period=TIMEOUT is reported, period_valid=1, and sig_lost is not set.
- Counter overflow: cnt never exceeds TIMEOUT-1, so no saturation logic is needed.
- `period` holds its last value between pulses.

Decomposition:
- Package zero_cross_pkg:
  - State enum typedef (ST_INIT, ST_LOW, ST_HIGH).
  - Signed hi/lo threshold helper function.
- Sub-module zc_hyst_slicer: holds the hysteresis state machine and emits a registered-free one-cycle `rise` strobe qualified by din_valid.
- The parent module owns armed, cnt, timeout logic and the output registers.

Test Plan (DIN_WIDTH=24, HYST=64, TIMEOUT=1000):
1. Square wave ±1000, 10 samples high / 10 samples low, din_valid every cycle -> first rise produces no pulse; every later rise gives period=20 with a one-cycle period_valid; sig_lost=0.
2. Same square wave with random 0–11 idle cycles between valids -> period remains 20 on every pulse, independent of clock gaps.
3. After arming, feed alternating +60/-60 (inside the band) -> no period_valid. sig_lost=0 after 999 samples; sig_lost=1 registered on the 1000th sample; next clean rise only re-arms; the rise after that reports the period and clears sig_lost.
4. Arm, hold low for 998 samples, then rise on the 1000th sample -> period=1000, period_valid=1, sig_lost stays 0 (crossing has priority).
5. Samples exactly +64 / -64 after ST_LOW -> no transition, no event. Sample +65 -> rise event.
6. Assert rst for one cycle mid-period after several measurements -> period=0, period_valid=0, sig_lost=0. The next rise only arms; the one after that reports the correct period.
